// File: rtl/wb_host_master_if.sv
// Command/response streams plus the Wishbone classic master bus of wb_host_master.
// The master modport is the wb_host_master view. The slave modport is the sequencer and slave view.
interface wb_host_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer master: one bus cycle per command, with an optional ack timeout.
// Each command returns one response, which carries either the read data or a timeout error.
module wb_host_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_host_master_if.master   bus,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   err_count
);

  localparam int unsigned     ToW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ToW-1:0]  ToLast = (TIMEOUT == 0) ? '0 : ToW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_dat_q, rsp_dat_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   txn_q, txn_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [ToW-1:0]     to_q, to_d;

  logic timeout_hit;
  assign timeout_hit = (TIMEOUT != 0) && (to_q == ToLast);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    txn_d       = txn_q;
    err_d       = err_q;
    to_d        = to_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          we_d    = bus.cmd_we;
          sel_d   = bus.cmd_sel;
          adr_d   = bus.cmd_adr;
          dat_d   = bus.cmd_dat;
          cyc_d   = 1'b1;
          to_d    = '0;
          state_d = StBus;
        end
      end
      StBus: begin
        // Ack takes priority over a timeout that expires on the same edge.
        if (bus.wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? 32'h0 : bus.wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          txn_d       = txn_q + CNT_W'(1);
          state_d     = StResp;
        end else if (timeout_hit) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          txn_d       = txn_q + CNT_W'(1);
          err_d       = err_q + CNT_W'(1);
          state_d     = StResp;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      txn_q       <= '0;
      err_q       <= '0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      txn_q       <= txn_d;
      err_q       <= err_d;
      to_q        <= to_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign txn_count     = txn_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench for wb_host_master. Each transaction's expected outcome comes from its wait count.
// Narrow counters let the random phase exercise counter wrap.
module tb_wb_host_master;
  localparam int unsigned T  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] txn_count, err_count;

  wb_host_master_if bus_if ();

  wb_host_master #(.TIMEOUT(T), .CNT_W(CW)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus_if),
    .txn_count (txn_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [CW-1:0] exp_txn = '0;
  logic [CW-1:0] exp_err = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // One command. The slave acks on cyc cycle waits+1, so a wait count of T or more means a timeout.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int waits, input logic [31:0] rdata,
                         input int bp);
    int          cyc_n;
    int          exp_n;
    logic        exp_e;
    logic [31:0] exp_d;
    exp_n = (waits + 1 < int'(T)) ? waits + 1 : int'(T);
    exp_e = (waits + 1 > int'(T));
    exp_d = (exp_e || we) ? 32'h0 : rdata;

    check_eq("cmd_ready_idle", 64'(bus_if.cmd_ready), 64'd1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_we    = we;
    bus_if.cmd_adr   = adr;
    bus_if.cmd_dat   = dat;
    bus_if.cmd_sel   = sel;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_we    = 1'($urandom);
    bus_if.cmd_adr   = $urandom;
    bus_if.cmd_dat   = $urandom;
    bus_if.cmd_sel   = 4'($urandom);

    cyc_n = 0;
    while (bus_if.wbm_cyc_o === 1'b1 && cyc_n < 4 * int'(T) + 8) begin
      cyc_n++;
      check_eq("bus_stb", 64'(bus_if.wbm_stb_o), 64'd1);
      check_eq("bus_we", 64'(bus_if.wbm_we_o), 64'(we));
      check_eq("bus_adr", 64'(bus_if.wbm_adr_o), 64'(adr));
      check_eq("bus_dat", 64'(bus_if.wbm_dat_o), 64'(dat));
      check_eq("bus_sel", 64'(bus_if.wbm_sel_o), 64'(sel));
      check_eq("bus_cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
      if (cyc_n == waits + 1) begin
        bus_if.wbm_ack_i = 1'b1;
        bus_if.wbm_dat_i = rdata;
      end else begin
        bus_if.wbm_ack_i = 1'b0;
        bus_if.wbm_dat_i = $urandom;
      end
      @(negedge clk);
    end
    bus_if.wbm_ack_i = 1'b0;
    exp_txn = exp_txn + 1'b1;
    if (exp_e) exp_err = exp_err + 1'b1;

    check_eq("cyc_len", 64'(cyc_n), 64'(exp_n));
    check_eq("rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
    check_eq("rsp_dat", 64'(bus_if.rsp_dat), 64'(exp_d));
    check_eq("rsp_err", 64'(bus_if.rsp_err), 64'(exp_e));
    check_eq("txn_count", 64'(txn_count), 64'(exp_txn));
    check_eq("err_count", 64'(err_count), 64'(exp_err));

    // Backpressure. Stray acks here must be ignored.
    for (int i = 0; i < bp; i++) begin
      bus_if.rsp_ready = 1'b0;
      bus_if.wbm_ack_i = 1'($urandom);
      bus_if.wbm_dat_i = $urandom;
      @(negedge clk);
      check_eq("bp_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
      check_eq("bp_rsp_dat", 64'(bus_if.rsp_dat), 64'(exp_d));
      check_eq("bp_rsp_err", 64'(bus_if.rsp_err), 64'(exp_e));
      check_eq("bp_cyc", 64'(bus_if.wbm_cyc_o), 64'd0);
      check_eq("bp_cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
      check_eq("bp_adr_hold", 64'(bus_if.wbm_adr_o), 64'(adr));
      check_eq("bp_txn_count", 64'(txn_count), 64'(exp_txn));
    end
    bus_if.wbm_ack_i = 1'b0;
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    check_eq("rsp_done_valid", 64'(bus_if.rsp_valid), 64'd0);
    check_eq("rsp_done_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
  endtask

  // Idle cycles with acks on the bus: these must not produce a response or change the counters.
  task automatic idle_spurious(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.wbm_ack_i = 1'b1;
      @(negedge clk);
      check_eq("idle_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
      check_eq("idle_cyc", 64'(bus_if.wbm_cyc_o), 64'd0);
      check_eq("idle_txn", 64'(txn_count), 64'(exp_txn));
      check_eq("idle_err", 64'(err_count), 64'(exp_err));
    end
    bus_if.wbm_ack_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_we    = 1'b0;
    bus_if.cmd_adr   = '0;
    bus_if.cmd_dat   = '0;
    bus_if.cmd_sel   = '0;
    bus_if.rsp_ready = 1'b0;
    bus_if.wbm_ack_i = 1'b0;
    bus_if.wbm_dat_i = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_cyc", 64'(bus_if.wbm_cyc_o), 64'd0);
    check_eq("rst_stb", 64'(bus_if.wbm_stb_o), 64'd0);
    check_eq("rst_we", 64'(bus_if.wbm_we_o), 64'd0);
    check_eq("rst_adr", 64'(bus_if.wbm_adr_o), 64'd0);
    check_eq("rst_dat", 64'(bus_if.wbm_dat_o), 64'd0);
    check_eq("rst_sel", 64'(bus_if.wbm_sel_o), 64'd0);
    check_eq("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    check_eq("rst_rsp_dat", 64'(bus_if.rsp_dat), 64'd0);
    check_eq("rst_rsp_err", 64'(bus_if.rsp_err), 64'd0);
    check_eq("rst_txn", 64'(txn_count), 64'd0);
    check_eq("rst_err", 64'(err_count), 64'd0);
    check_eq("rst_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h1234_5678, 0);
    run_txn(1'b0, 32'h3000_0010, 32'hCAFE_0001, 4'hF, 3, 32'h0000_01FF, 1);
    run_txn(1'b0, 32'h3000_0020, 32'h0,         4'h3, 100, 32'hFFFF_FFFF, 0);
    run_txn(1'b0, 32'h3000_0024, 32'h0,         4'h1, int'(T) - 1, 32'h0000_0055, 0);
    run_txn(1'b1, 32'h3000_0028, 32'h0BAD_F00D, 4'hC, int'(T), 32'h0, 5);
    idle_spurious(3);

    // Reset asserted on the second cyc cycle.
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_we    = 1'b0;
    bus_if.cmd_adr   = 32'h3000_0100;
    bus_if.cmd_sel   = 4'hF;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_cyc", 64'(bus_if.wbm_cyc_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_txn = '0;
    exp_err = '0;
    check_eq("midrst_cyc", 64'(bus_if.wbm_cyc_o), 64'd0);
    check_eq("midrst_stb", 64'(bus_if.wbm_stb_o), 64'd0);
    check_eq("midrst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    check_eq("midrst_txn", 64'(txn_count), 64'd0);
    check_eq("midrst_err", 64'(err_count), 64'd0);
    check_eq("midrst_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);

    // Randomized traffic. More than 2**CW transactions exercise counter wrap.
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
              int'($urandom_range(0, T + 3)), $urandom, int'($urandom_range(0, 3)));
      idle_spurious(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
